arp_rx_parser: RTL and testbench

// Receive-side ARP decoder: consumes ARP payload bytes (Ethernet header already stripped, EtherType 0x0806

---
 rtl/arp_rx_parser.sv | 168 ++++++++++++++++
 tb/tb_arp_rx_parser.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_rx_parser.sv
// Receive-side ARP decoder: checks ARP payload bytes from an 8-bit AXI-Stream,
// raises a held response request for ARP requests to LOCAL_IP and pulses on accepted replies.
module arp_rx_parser #(
    parameter logic [31:0] LOCAL_IP  = 32'hC0A8_0164,
    parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
    parameter bit          CHECK_THA = 1'b1
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        s_axis_tready,
    output logic        arp_resp_start,
    input  logic        arp_resp_ack,
    output logic [47:0] resp_sha,
    output logic [31:0] resp_spa,
    output logic        rx_reply_valid,
    output logic [47:0] rx_sha,
    output logic [31:0] rx_spa,
    output logic [15:0] drop_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PARSE = 2'd1,
        DRAIN = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t      r_state;
    logic [4:0]  r_byte_cnt;
    logic        r_tready;
    logic        r_oper_req;
    logic [47:0] r_sha;
    logic [31:0] r_spa;
    logic [47:0] r_tha;
    logic [31:0] r_tpa;

    logic        r_resp_start;
    logic [47:0] r_resp_sha;
    logic [31:0] r_resp_spa;
    logic        r_rx_valid;
    logic [47:0] r_rx_sha;
    logic [31:0] r_rx_spa;
    logic [15:0] r_drop_cnt;

    logic        w_beat;
    logic        w_parsing;
    logic        w_field_ok;
    logic        w_len_ok;
    logic [31:0] w_tpa_full;
    logic        w_accept;
    logic        w_req_acc;
    logic        w_rep_acc;

    assign w_beat    = s_axis_tvalid && r_tready;
    assign w_parsing = (r_state == IDLE) || (r_state == PARSE);

    // Fixed header bytes; OPER high byte must be zero and low byte 1 or 2
    always_comb begin
        w_field_ok = 1'b1;
        case (r_byte_cnt)
            5'd0:    w_field_ok = (s_axis_tdata == 8'h00);
            5'd1:    w_field_ok = (s_axis_tdata == 8'h01);
            5'd2:    w_field_ok = (s_axis_tdata == 8'h08);
            5'd3:    w_field_ok = (s_axis_tdata == 8'h00);
            5'd4:    w_field_ok = (s_axis_tdata == 8'h06);
            5'd5:    w_field_ok = (s_axis_tdata == 8'h04);
            5'd6:    w_field_ok = (s_axis_tdata == 8'h00);
            5'd7:    w_field_ok = (s_axis_tdata == 8'h01) || (s_axis_tdata == 8'h02);
            default: w_field_ok = 1'b1;
        endcase
    end

    // When tlast lands on byte 27 the final TPA byte is still on the bus
    assign w_tpa_full = (r_state == DRAIN) ? r_tpa : {r_tpa[23:0], s_axis_tdata};
    assign w_len_ok   = (w_parsing && (r_byte_cnt == 5'd27)) || (r_state == DRAIN);
    assign w_accept   = w_beat && s_axis_tlast && !s_axis_tuser && w_len_ok
                        && (w_tpa_full == LOCAL_IP);
    assign w_req_acc  = w_accept && r_oper_req;
    assign w_rep_acc  = w_accept && !r_oper_req
                        && ((CHECK_THA == 1'b0) || (r_tha == LOCAL_MAC));

    always_ff @(posedge aclk) begin
        if (w_beat && w_parsing) begin
            if (r_byte_cnt == 5'd7)
                r_oper_req <= (s_axis_tdata == 8'h01);
            if ((r_byte_cnt >= 5'd8) && (r_byte_cnt <= 5'd13))
                r_sha <= {r_sha[39:0], s_axis_tdata};
            if ((r_byte_cnt >= 5'd14) && (r_byte_cnt <= 5'd17))
                r_spa <= {r_spa[23:0], s_axis_tdata};
            if ((r_byte_cnt >= 5'd18) && (r_byte_cnt <= 5'd23))
                r_tha <= {r_tha[39:0], s_axis_tdata};
            if ((r_byte_cnt >= 5'd24) && (r_byte_cnt <= 5'd27))
                r_tpa <= {r_tpa[23:0], s_axis_tdata};
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= IDLE;
            r_byte_cnt   <= 5'd0;
            r_tready     <= 1'b0;
            r_resp_start <= 1'b0;
            r_resp_sha   <= 48'd0;
            r_resp_spa   <= 32'd0;
            r_rx_valid   <= 1'b0;
            r_rx_sha     <= 48'd0;
            r_rx_spa     <= 32'd0;
            r_drop_cnt   <= 16'd0;
        end else begin
            r_tready   <= 1'b1;
            r_rx_valid <= w_rep_acc;

            if (w_beat) begin
                case (r_state)
                    IDLE, PARSE: begin
                        if (s_axis_tlast) begin
                            r_state    <= IDLE;
                            r_byte_cnt <= 5'd0;
                        end else if (!w_field_ok) begin
                            r_state    <= DROP;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 5'd1;
                            r_state    <= (r_byte_cnt == 5'd27) ? DRAIN : PARSE;
                        end
                    end
                    default: begin
                        if (s_axis_tlast) begin
                            r_state    <= IDLE;
                            r_byte_cnt <= 5'd0;
                        end
                    end
                endcase
            end

            // A new request on the ack edge replaces the one being acknowledged
            if (w_req_acc) begin
                if (!r_resp_start || arp_resp_ack) begin
                    r_resp_start <= 1'b1;
                    r_resp_sha   <= r_sha;
                    r_resp_spa   <= r_spa;
                end else if (r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt   <= r_drop_cnt + 16'd1;
                end
            end else if (arp_resp_ack) begin
                r_resp_start <= 1'b0;
            end

            if (w_rep_acc) begin
                r_rx_sha <= r_sha;
                r_rx_spa <= r_spa;
            end
        end
    end

    assign s_axis_tready  = r_tready;
    assign arp_resp_start = r_resp_start;
    assign resp_sha       = r_resp_sha;
    assign resp_spa       = r_resp_spa;
    assign rx_reply_valid = r_rx_valid;
    assign rx_sha         = r_rx_sha;
    assign rx_spa         = r_rx_spa;
    assign drop_cnt       = r_drop_cnt;

endmodule

// File: tb/tb_arp_rx_parser.sv
// Self-checking bench for arp_rx_parser: directed frames followed by randomized frames,
// compared against a frame-level reference model.
module tb_arp_rx_parser;

    localparam logic [31:0] LIP  = 32'hC0A8_0164;
    localparam logic [47:0] LMAC = 48'h02_00_00_00_00_01;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [7:0]  s_axis_tdata = 8'h00;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic        s_axis_tready;
    logic        arp_resp_start;
    logic        arp_resp_ack = 1'b0;
    logic [47:0] resp_sha;
    logic [31:0] resp_spa;
    logic        rx_reply_valid;
    logic [47:0] rx_sha;
    logic [31:0] rx_spa;
    logic [15:0] drop_cnt;

    arp_rx_parser dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tready (s_axis_tready),
        .arp_resp_start(arp_resp_start),
        .arp_resp_ack  (arp_resp_ack),
        .resp_sha      (resp_sha),
        .resp_spa      (resp_spa),
        .rx_reply_valid(rx_reply_valid),
        .rx_sha        (rx_sha),
        .rx_spa        (rx_spa),
        .drop_cnt      (drop_cnt)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int failures = 0;

    logic [7:0]  fr [0:63];
    int          fr_len;

    logic        exp_start;
    logic [47:0] exp_sha;
    logic [31:0] exp_spa;
    logic        exp_rxv;
    logic [47:0] exp_rx_sha;
    logic [31:0] exp_rx_spa;
    logic [15:0] exp_drop;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        exp_start  = 1'b0;
        exp_sha    = 48'd0;
        exp_spa    = 32'd0;
        exp_rxv    = 1'b0;
        exp_rx_sha = 48'd0;
        exp_rx_spa = 32'd0;
        exp_drop   = 16'd0;
    endtask

    task automatic build(input logic [15:0] oper, input logic [47:0] sha, input logic [31:0] spa,
                         input logic [47:0] tha, input logic [31:0] tpa, input int len);
        fr[0] = 8'h00; fr[1] = 8'h01; fr[2] = 8'h08; fr[3] = 8'h00;
        fr[4] = 8'h06; fr[5] = 8'h04; fr[6] = oper[15:8]; fr[7] = oper[7:0];
        for (int i = 0; i < 6; i++) begin
            fr[8 + i]  = sha[47 - 8*i -: 8];
            fr[18 + i] = tha[47 - 8*i -: 8];
        end
        for (int i = 0; i < 4; i++) begin
            fr[14 + i] = spa[31 - 8*i -: 8];
            fr[24 + i] = tpa[31 - 8*i -: 8];
        end
        for (int i = 28; i < 64; i++) fr[i] = 8'($urandom);
        fr_len = len;
    endtask

    // Frame-level reference: decide from the whole byte array what the frame means
    task automatic model_frame(input logic tuser, input bit ack_last);
        logic [47:0] sha, tha;
        logic [31:0] spa, tpa;
        bit ok, is_req, is_rep;
        sha = {fr[8], fr[9], fr[10], fr[11], fr[12], fr[13]};
        spa = {fr[14], fr[15], fr[16], fr[17]};
        tha = {fr[18], fr[19], fr[20], fr[21], fr[22], fr[23]};
        tpa = {fr[24], fr[25], fr[26], fr[27]};
        ok = (fr_len >= 28) && !tuser
             && ({fr[0], fr[1]} == 16'h0001) && ({fr[2], fr[3]} == 16'h0800)
             && (fr[4] == 8'd6) && (fr[5] == 8'd4)
             && (({fr[6], fr[7]} == 16'd1) || ({fr[6], fr[7]} == 16'd2))
             && (tpa == LIP);
        is_req = ok && ({fr[6], fr[7]} == 16'd1);
        is_rep = ok && ({fr[6], fr[7]} == 16'd2) && (tha == LMAC);
        if (is_req) begin
            if (!exp_start || ack_last) begin
                exp_start = 1'b1;
                exp_sha   = sha;
                exp_spa   = spa;
            end else if (exp_drop != 16'hFFFF) begin
                exp_drop++;
            end
        end else if (ack_last) begin
            exp_start = 1'b0;
        end
        exp_rxv = is_rep;
        if (is_rep) begin
            exp_rx_sha = sha;
            exp_rx_spa = spa;
        end
    endtask

    // Called at #1 after a rising edge; returns at #1 after the edge that takes the last beat
    task automatic send(input int n, input logic tuser, input int gap_pct, input bit ack_last);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                @(posedge aclk); #1;
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = fr[i];
            s_axis_tlast  = (i == fr_len - 1);
            s_axis_tuser  = (i == fr_len - 1) ? tuser : 1'b0;
            arp_resp_ack  = (i == fr_len - 1) && ack_last;
            @(posedge aclk); #1;
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            s_axis_tuser  = 1'b0;
            arp_resp_ack  = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".start"}, 64'(arp_resp_start), 64'(exp_start));
        if (exp_start) begin
            chk({tag, ".resp_sha"}, 64'(resp_sha), 64'(exp_sha));
            chk({tag, ".resp_spa"}, 64'(resp_spa), 64'(exp_spa));
        end
        chk({tag, ".rxv"}, 64'(rx_reply_valid), 64'(exp_rxv));
        chk({tag, ".rx_sha"}, 64'(rx_sha), 64'(exp_rx_sha));
        chk({tag, ".rx_spa"}, 64'(rx_spa), 64'(exp_rx_spa));
        chk({tag, ".drop"}, 64'(drop_cnt), 64'(exp_drop));
    endtask

    task automatic frame(input string tag, input logic tuser, input int gap_pct, input bit ack_last);
        send(fr_len, tuser, gap_pct, ack_last);
        model_frame(tuser, ack_last);
        check_all(tag);
        @(posedge aclk); #1;
        exp_rxv = 1'b0;
        chk({tag, ".rxv_pulse"}, 64'(rx_reply_valid), 64'(exp_rxv));
    endtask

    task automatic ack(input string tag);
        arp_resp_ack = 1'b1;
        @(posedge aclk); #1;
        arp_resp_ack = 1'b0;
        exp_start = 1'b0;
        chk({tag, ".ack"}, 64'(arp_resp_start), 64'(exp_start));
    endtask

    task automatic reset_check(input string tag);
        chk({tag, ".tready"}, 64'(s_axis_tready), 64'd0);
        chk({tag, ".zero"}, {63'd0, arp_resp_start | rx_reply_valid}, 64'd0);
        chk({tag, ".zero_data"}, 64'(resp_sha | rx_sha | 48'(resp_spa) | 48'(rx_spa) | 48'(drop_cnt)), 64'd0);
    endtask

    initial begin
        model_reset();
        #1;
        repeat (3) @(posedge aclk);
        #1;
        reset_check("rst");
        aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("rst.tready_up", 64'(s_axis_tready), 64'd1);

        // 1: basic request, then ack
        build(16'd1, 48'h0011_2233_4455, 32'hC0A8_0101, 48'd0, LIP, 28);
        frame("t1", 1'b0, 0, 1'b0);
        ack("t1");

        // 2: reply addressed to us
        build(16'd2, 48'hAABB_CCDD_EEFF, 32'hC0A8_0102, LMAC, LIP, 28);
        frame("t2", 1'b0, 0, 1'b0);
        build(16'd2, 48'h1111_2222_3333, 32'hC0A8_0103, 48'h0200_0000_0002, LIP, 28);
        frame("t2.badtha", 1'b0, 0, 1'b0);

        // 3: discard cases
        build(16'd1, 48'h0011_2233_4455, 32'hC0A8_0101, 48'd0, 32'hC0A8_0199, 28);
        frame("t3.tpa", 1'b0, 0, 1'b0);
        build(16'd1, 48'h0011_2233_4455, 32'hC0A8_0101, 48'd0, LIP, 28);
        fr[2] = 8'h86; fr[3] = 8'hDD;
        frame("t3.ptype", 1'b0, 0, 1'b0);
        build(16'd1, 48'h0011_2233_4455, 32'hC0A8_0101, 48'd0, LIP, 21);
        frame("t3.short", 1'b0, 0, 1'b0);
        build(16'd1, 48'h0011_2233_4455, 32'hC0A8_0101, 48'd0, LIP, 28);
        frame("t3.tuser", 1'b1, 0, 1'b0);
        build(16'd1, 48'h0A0B_0C0D_0E0F, 32'h0000_0000, 48'd0, LIP, 28);
        frame("t3.clean", 1'b0, 0, 1'b0);

        // 4: back-to-back requests, then a request coinciding with ack
        build(16'd1, 48'h1234_5678_9ABC, 32'hC0A8_0110, 48'd0, LIP, 28);
        frame("t4.second", 1'b0, 0, 1'b0);
        build(16'd1, 48'hCAFE_0000_BEEF, 32'hC0A8_0111, 48'd0, LIP, 28);
        frame("t4.ackwin", 1'b0, 0, 1'b1);
        ack("t4");

        // 5: padded frame with gaps, then reset mid-frame
        build(16'd1, 48'h5566_7788_99AA, 32'hC0A8_0120, 48'd0, LIP, 46);
        frame("t5.pad", 1'b0, 30, 1'b0);
        build(16'd2, 48'h5566_7788_99AB, 32'hC0A8_0121, LMAC, LIP, 40);
        send(15, 1'b0, 20, 1'b0);
        #2 aresetn = 1'b0;
        #1;
        reset_check("t5.rst");
        model_reset();
        @(posedge aclk); #1;
        aresetn = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        build(16'd2, 48'h0102_0304_0506, 32'hC0A8_0130, LMAC, LIP, 30);
        frame("t5.after", 1'b0, 10, 1'b0);

        // Randomized frames
        for (int n = 0; n < 200; n++) begin
            logic [15:0] oper;
            int len, r;
            logic tuser;
            oper = ($urandom_range(0, 9) == 0) ? 16'd3 : 16'($urandom_range(1, 2));
            len  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 27) : $urandom_range(28, 46);
            build(oper, {$urandom, $urandom}, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
                  ($urandom_range(0, 4) == 0) ? {$urandom, $urandom} : LMAC,
                  ($urandom_range(0, 4) == 0) ? $urandom : LIP, len);
            if ($urandom_range(0, 9) == 0) begin
                r = $urandom_range(0, 6);
                fr[r] = fr[r] ^ 8'($urandom_range(1, 255));
            end
            tuser = ($urandom_range(0, 9) == 0);
            frame("rnd", tuser, 15, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) ack("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
